// File: rtl/toothless_lsu.sv
// Toothless core load/store unit: turns one execute-stage load/store into a
// req/gnt/rvalid bus transaction and formats the returned load data.
module toothless_lsu #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [2:0]            lsu_funct3_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [31:0]           lsu_wdata_i,
    output logic                  lsu_busy_o,
    output logic                  lsu_rvalid_o,
    output logic [31:0]           lsu_rdata_o,
    output logic                  lsu_err_o,

    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i,
    input  logic                  data_err_i
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID
    } state_e;

    state_e state_q, state_d;

    logic [1:0]            off_q;
    logic [2:0]            funct3_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;
    logic                  rvalid_q;
    logic                  err_q;
    logic [31:0]           rdata_q;

    logic                  legal;
    logic                  misaligned;
    logic                  accept;
    logic                  reject;
    logic                  complete;
    logic [3:0]            be_d;
    logic [31:0]           wdata_d;
    logic [31:0]           load_data;

    // Request decode: encoding legality, alignment, lane mapping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        legal      = 1'b0;
        misaligned = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = lsu_wdata_i;

        if (lsu_we_i) begin
            legal = (lsu_funct3_i == 3'b000) || (lsu_funct3_i == 3'b001) ||
                    (lsu_funct3_i == 3'b010);
        end else begin
            legal = (lsu_funct3_i == 3'b000) || (lsu_funct3_i == 3'b001) ||
                    (lsu_funct3_i == 3'b010) || (lsu_funct3_i == 3'b100) ||
                    (lsu_funct3_i == 3'b101);
        end

        unique case (lsu_funct3_i[1:0])
            2'b00: begin
                be_d    = 4'b0001 << lsu_addr_i[1:0];
                wdata_d = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = lsu_addr_i[0];
                be_d       = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_d    = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                misaligned = (lsu_addr_i[1:0] != 2'b00);
            end
        endcase
    end

    // Load extraction uses the offset and size latched at accept time.
    always_comb begin
        logic [7:0]  sel_b;
        logic [15:0] sel_h;

        unique case (off_q)
            2'b00:   sel_b = data_rdata_i[7:0];
            2'b01:   sel_b = data_rdata_i[15:8];
            2'b10:   sel_b = data_rdata_i[23:16];
            default: sel_b = data_rdata_i[31:24];
        endcase
        sel_h = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];

        unique case (funct3_q)
            3'b000:  load_data = {{24{sel_b[7]}}, sel_b};
            3'b100:  load_data = {24'h0, sel_b};
            3'b001:  load_data = {{16{sel_h[15]}}, sel_h};
            3'b101:  load_data = {16'h0, sel_h};
            default: load_data = data_rdata_i;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        reject   = 1'b0;
        complete = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    if (legal && !misaligned) begin
                        accept  = 1'b1;
                        state_d = WAIT_GNT;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            WAIT_GNT: begin
                if (data_gnt_i) state_d = WAIT_RVALID;
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Bus fields are captured once on accept and held stable until the grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            off_q    <= 2'b00;
            funct3_q <= 3'b000;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= 4'b0000;
            wdata_q  <= 32'h0;
        end else if (accept) begin
            off_q    <= lsu_addr_i[1:0];
            funct3_q <= lsu_funct3_i;
            we_q     <= lsu_we_i;
            addr_q   <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
            be_q     <= be_d;
            wdata_q  <= wdata_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            rvalid_q <= complete | reject;
            err_q    <= reject | (complete & data_err_i);
            if (complete && !we_q && !data_err_i) rdata_q <= load_data;
        end
    end

    assign data_req_o   = (state_q == WAIT_GNT);
    assign data_addr_o  = addr_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

    assign lsu_busy_o   = (state_q != IDLE);
    assign lsu_rvalid_o = rvalid_q;
    assign lsu_err_o    = err_q;
    assign lsu_rdata_o  = rdata_q;

endmodule

// File: tb/tb_toothless_lsu.sv
// Directed bench for toothless_lsu: table of single accesses with
// hand-computed results, plus stall, busy-drop and mid-transaction reset cases.
module tb_toothless_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_funct3_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_busy_o;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    toothless_lsu #(.ADDR_WIDTH(32)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .lsu_req_i     (lsu_req_i),
        .lsu_we_i      (lsu_we_i),
        .lsu_funct3_i  (lsu_funct3_i),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_busy_o    (lsu_busy_o),
        .lsu_rvalid_o  (lsu_rvalid_o),
        .lsu_rdata_o   (lsu_rdata_o),
        .lsu_err_o     (lsu_err_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .data_err_i    (data_err_i)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        bus_err;
        logic        bus;        // 1 = expect a bus transaction
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        lsu_req_i     = 1'b0;
        lsu_we_i      = 1'b0;
        lsu_funct3_i  = 3'b000;
        lsu_addr_i    = 32'h0;
        lsu_wdata_i   = 32'h0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
        data_err_i    = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(negedge clk_i);
        lsu_req_i    = 1'b1;
        lsu_we_i     = we;
        lsu_funct3_i = f3;
        lsu_addr_i   = addr;
        lsu_wdata_i  = wdata;
        @(posedge clk_i);
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.we, v.f3, v.addr, v.wdata);
        @(negedge clk_i);
        lsu_req_i = 1'b0;
        if (!v.bus) begin
            check({v.name, " no_req"}, 32'(data_req_o), 32'h0);
            check({v.name, " rvalid"}, 32'(lsu_rvalid_o), 32'h1);
            check({v.name, " err"}, 32'(lsu_err_o), 32'h1);
            check({v.name, " rdata"}, lsu_rdata_o, v.exp_rdata);
            return;
        end
        check({v.name, " req"}, 32'(data_req_o), 32'h1);
        check({v.name, " busy"}, 32'(lsu_busy_o), 32'h1);
        check({v.name, " addr"}, data_addr_o, v.exp_addr);
        check({v.name, " be"}, 32'(data_be_o), 32'(v.exp_be));
        check({v.name, " we"}, 32'(data_we_o), 32'(v.we));
        if (v.we) check({v.name, " wdata"}, data_wdata_o, v.exp_wdata);
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        check({v.name, " req_drop"}, 32'(data_req_o), 32'h0);
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = v.rdata;
        data_err_i    = v.bus_err;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        check({v.name, " rvalid"}, 32'(lsu_rvalid_o), 32'h1);
        check({v.name, " err"}, 32'(lsu_err_o), 32'(v.exp_err));
        check({v.name, " rdata"}, lsu_rdata_o, v.exp_rdata);
        check({v.name, " idle"}, 32'(lsu_busy_o), 32'h0);
    endtask

    initial begin
        //          name     we    f3      addr          wdata         rdata         berr  bus   exp_addr      be       exp_wdata     exp_rdata     err
        vecs[0]  = '{"LW",    1'b0, 3'b010, 32'h0000_1000, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 32'h0000_1000, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[1]  = '{"LB3",   1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80112233, 1'b0, 1'b1, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[2]  = '{"LBU3",  1'b0, 3'b100, 32'h0000_1003, 32'h0,        32'h80112233, 1'b0, 1'b1, 32'h0000_1000, 4'b1000, 32'h0,        32'h00000080, 1'b0};
        vecs[3]  = '{"LH2",   1'b0, 3'b001, 32'h0000_1002, 32'h0,        32'h80112233, 1'b0, 1'b1, 32'h0000_1000, 4'b1100, 32'h0,        32'hFFFF8011, 1'b0};
        vecs[4]  = '{"LHU0",  1'b0, 3'b101, 32'h0000_1000, 32'h0,        32'h80112233, 1'b0, 1'b1, 32'h0000_1000, 4'b0011, 32'h0,        32'h00002233, 1'b0};
        vecs[5]  = '{"LB1",   1'b0, 3'b000, 32'h0000_1001, 32'h0,        32'h80112233, 1'b0, 1'b1, 32'h0000_1000, 4'b0010, 32'h0,        32'h00000022, 1'b0};
        vecs[6]  = '{"SB2",   1'b1, 3'b000, 32'h0000_1002, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0000_1000, 4'b0100, 32'h78787878, 32'h00000022, 1'b0};
        vecs[7]  = '{"SW",    1'b1, 3'b010, 32'h0000_1004, 32'hCAFEBABE, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0000_1004, 4'b1111, 32'hCAFEBABE, 32'h00000022, 1'b0};
        vecs[8]  = '{"LWmis", 1'b0, 3'b010, 32'h0000_1002, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h00000022, 1'b1};
        vecs[9]  = '{"LHmis", 1'b0, 3'b001, 32'h0000_1001, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h00000022, 1'b1};
        vecs[10] = '{"L011",  1'b0, 3'b011, 32'h0000_1000, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h00000022, 1'b1};
        vecs[11] = '{"S100",  1'b1, 3'b100, 32'h0000_1000, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h00000022, 1'b1};
        vecs[12] = '{"LWerr", 1'b0, 3'b010, 32'h0000_3000, 32'h0,        32'h11111111, 1'b1, 1'b1, 32'h0000_3000, 4'b1111, 32'h0,        32'h00000022, 1'b1};
        vecs[13] = '{"LHU2",  1'b0, 3'b101, 32'h0000_1002, 32'h0,        32'hFEDC0000, 1'b0, 1'b1, 32'h0000_1000, 4'b1100, 32'h0,        32'h0000FEDC, 1'b0};

        drive_idle();
        rst_ni = 1'b0;
        #12;
        check("rst req", 32'(data_req_o), 32'h0);
        check("rst busy", 32'(lsu_busy_o), 32'h0);
        check("rst rvalid", 32'(lsu_rvalid_o), 32'h0);
        check("rst err", 32'(lsu_err_o), 32'h0);
        check("rst we", 32'(data_we_o), 32'h0);
        check("rst be", 32'(data_be_o), 32'h0);
        check("rst addr", data_addr_o, 32'h0);
        check("rst wdata", data_wdata_o, 32'h0);
        check("rst rdata", lsu_rdata_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // SH with grant withheld for three cycles: bus fields must hold.
        issue(1'b1, 3'b001, 32'h0000_2002, 32'h0000ABCD);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            lsu_req_i = 1'b0;
            check("SH stall req", 32'(data_req_o), 32'h1);
            check("SH stall addr", data_addr_o, 32'h0000_2000);
            check("SH stall be", 32'(data_be_o), 32'hC);
            check("SH stall wdata", data_wdata_o, 32'hABCDABCD);
            data_gnt_i = (c == 3);
        end
        @(negedge clk_i);
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h55555555;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        check("SH rvalid", 32'(lsu_rvalid_o), 32'h1);
        check("SH err", 32'(lsu_err_o), 32'h0);
        check("SH rdata kept", lsu_rdata_o, 32'h0000FEDC);
        @(negedge clk_i);
        check("SH rvalid pulse", 32'(lsu_rvalid_o), 32'h0);

        // Bus error load with a second request pulsed while busy.
        issue(1'b0, 3'b010, 32'h0000_3000, 32'h0);
        @(negedge clk_i);
        lsu_addr_i = 32'h0000_4000;
        check("busy req1", 32'(data_req_o), 32'h1);
        @(negedge clk_i);
        lsu_req_i  = 1'b0;
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_err_i    = 1'b1;
        data_rdata_i  = 32'h99999999;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        check("berr rvalid", 32'(lsu_rvalid_o), 32'h1);
        check("berr err", 32'(lsu_err_o), 32'h1);
        check("berr rdata kept", lsu_rdata_o, 32'h0000FEDC);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            check("dropped req", 32'(data_req_o), 32'h0);
            check("dropped busy", 32'(lsu_busy_o), 32'h0);
        end

        // Asynchronous reset while waiting for grant.
        issue(1'b0, 3'b010, 32'h0000_1000, 32'h0);
        @(negedge clk_i);
        lsu_req_i = 1'b0;
        check("pre-rst req", 32'(data_req_o), 32'h1);
        #2 rst_ni = 1'b0;
        #1;
        check("async rst req", 32'(data_req_o), 32'h0);
        check("async rst busy", 32'(lsu_busy_o), 32'h0);
        @(negedge clk_i);
        rst_ni        = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h12345678;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        check("stray rvalid", 32'(lsu_rvalid_o), 32'h0);
        check("stray rdata", lsu_rdata_o, 32'h0);
        @(negedge clk_i);
        check("stray rvalid2", 32'(lsu_rvalid_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
